// File: rtl/cpu_control_fsm_if.sv
// Memory and decoder bus between the control FSM and the outside world.
// The master is the control FSM. The slave is the memory plus decoder side.
interface cpu_control_fsm_if;
  // Memory port
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  // Decoder port
  logic [31:0] code;
  logic        en_de;
  logic [5:0]  opcode_cpu;
  logic [1:0]  func_cpu;
  logic [23:0] addr_cpu;

  modport master (
    output mem_req, mem_we, mem_addr, code, en_de,
    input  mem_rdata, mem_ready, opcode_cpu, func_cpu, addr_cpu
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, code, en_de,
    output mem_rdata, mem_ready, opcode_cpu, func_cpu, addr_cpu
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer.
// It owns the PC and the instruction register. It fetches over a ready-handshake
// memory port and issues one-cycle strobes to the decoder, ALU, register file and memory.
module cpu_control_fsm #(
  parameter logic [23:0] PC_RESET = 24'h000000,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     zero_flag,
  cpu_control_fsm_if.master        bus,
  output logic                     alu_en,
  output logic [1:0]               func_q,
  output logic [23:0]              addr_q,
  output logic                     reg_we,
  output logic [23:0]              pc,
  output logic                     illegal,
  output logic                     halted,
  output logic [2:0]               state_o
);

  localparam logic [5:0] OpAlu   = 6'h00;
  localparam logic [5:0] OpLoad  = 6'h01;
  localparam logic [5:0] OpStore = 6'h02;
  localparam logic [5:0] OpJmp   = 6'h03;
  localparam logic [5:0] OpBeqz  = 6'h04;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] pc_q, pc_d;
  logic [31:0] code_q, code_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  func_d;
  logic [23:0] addr_d;
  logic        illegal_q, illegal_d;
  logic        is_halt;

  // HALT_OP is a parameter, so it takes priority over the fixed opcodes.
  assign is_halt = (op_q == HALT_OP);

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= PC_RESET;
      code_q    <= 32'h0;
      op_q      <= 6'h0;
      func_q    <= 2'h0;
      addr_q    <= 24'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      code_q    <= code_d;
      op_q      <= op_d;
      func_q    <= func_d;
      addr_q    <= addr_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    code_d    = code_q;
    op_d      = op_q;
    func_d    = func_q;
    addr_d    = addr_q;
    illegal_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (bus.mem_ready) begin
          code_d  = bus.mem_rdata;
          pc_d    = pc_q + 24'd1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // The decoder is combinational from code_q, so its fields are valid now.
        op_d    = bus.opcode_cpu;
        func_d  = bus.func_cpu;
        addr_d  = bus.addr_cpu;
        state_d = StExec;
      end
      StExec: begin
        if (is_halt) begin
          state_d = StHalt;
        end else begin
          case (op_q)
            OpAlu:          state_d = StWb;
            OpLoad, OpStore: state_d = StMem;
            OpJmp: begin
              pc_d    = addr_q;
              state_d = StFetch;
            end
            OpBeqz: begin
              if (zero_flag) pc_d = addr_q;
              state_d = StFetch;
            end
            default: begin
              // Unknown opcode: flag it and treat it as a NOP.
              illegal_d = 1'b1;
              state_d   = StFetch;
            end
          endcase
        end
      end
      StMem: begin
        if (bus.mem_ready) state_d = (op_q == OpStore) ? StFetch : StWb;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 24'h0;
    bus.en_de    = 1'b0;
    alu_en       = 1'b0;
    reg_we       = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pc_q;
      end
      StDecode: bus.en_de = 1'b1;
      StExec:   alu_en = !is_halt && (op_q == OpAlu);
      StMem: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = (op_q == OpStore);
        bus.mem_addr = addr_q;
      end
      StWb:    reg_we = 1'b1;
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.code = code_q;
  assign pc       = pc_q;
  assign illegal  = illegal_q;
  assign state_o  = state_q;

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle fetch/decode/execute sequencer for the 32-bit CPU. It owns the PC and instruction register, fetches words over a ready-handshake memory port, and presents the instruction to the decoder as `code` with an `en_de` strobe. It then consumes the decoder fields (`opcode_cpu`, `func_cpu`, `addr_cpu`) and issues one-cycle strobes to the ALU, register file and memory. It sits between instruction/data memory and the decoder/datapath.

Parameters:
PC_RESET, 24'h000000, PC value loaded on reset.
HALT_OP, 6'h3F, opcode that halts the core.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  leaves IDLE (level or pulse, sampled in IDLE only)
mem_rdata  input  32  read data from memory
mem_ready  input  1  memory completes the current request this cycle
zero_flag  input  1  ALU zero flag, used by BEQZ
opcode_cpu  input  6  from decoder
func_cpu  input  2  from decoder
addr_cpu  input  24  from decoder
code  output  32  instruction register, drives decoder
en_de  output  1  decoder enable strobe
mem_req  output  1  memory request
mem_we  output  1  memory write (valid with mem_req)
mem_addr  output  24  memory address
alu_en  output  1  ALU execute strobe; func passed via func_q
func_q  output  2  latched func field
addr_q  output  24  latched address field, also the store/load address
reg_we  output  1  register-file write strobe
pc  output  24  program counter
illegal  output  1  one-cycle pulse on unknown opcode
halted  output  1  high while in HALT
state_o  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6

Behaviour:
- Reset (any state, any cycle): next state is IDLE, with `pc`=PC_RESET. `code`, `func_q` and `addr_q` are 0. All strobes, `mem_req`, `halted` and `illegal` are 0. Reset mid-request drops `mem_req` the next cycle, with no completion.
- Strobes are Moore outputs decoded from the registered state. Registered values are `code`, `pc`, `func_q`, `addr_q` and `illegal`.
- Opcodes:
  - 6'h00 ALU
  - 6'h01 LOAD
  - 6'h02 STORE
  - 6'h03 JMP
  - 6'h04 BEQZ
  - HALT_OP HALT
  - all others illegal
- IDLE: all outputs idle. If `start`=1, go to FETCH.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. Stay while `mem_ready`=0. On `mem_ready`=1: `code`<=`mem_rdata`, `pc`<=`pc`+1 (24-bit wrap, FFFFFF->000000), go to DECODE.
- DECODE: `en_de`=1 for exactly one cycle. The decoder is combinational: latch `func_q`<=`func_cpu`, `addr_q`<=`addr_cpu`, op_q<=`opcode_cpu`. Go to EXEC.
- EXEC, by op_q:
  - ALU: `alu_en`=1, go to WB.
  - LOAD/STORE: go to MEM.
  - JMP: `pc`<=`addr_q`, go to FETCH.
  - BEQZ: if `zero_flag`=1 then `pc`<=`addr_q`, else `pc` unchanged; go to FETCH.
  - HALT: go to HALT.
  - illegal: `illegal`<=1 for one cycle, treated as NOP, go to FETCH.
- MEM: `mem_req`=1, `mem_addr`=`addr_q`, `mem_we`=1 iff STORE. Wait for `mem_ready`. LOAD goes to WB; STORE goes to FETCH.
- WB: `reg_we`=1 for one cycle, go to FETCH.
- HALT: `halted`=1. Stays until `rst`; `start` is ignored.
- `mem_ready` outside FETCH/MEM is ignored.
- With `mem_ready` tied high, FETCH and MEM each last exactly one cycle.
- Instruction latency in cycles with zero-wait memory: ALU 4, LOAD 5, STORE 4, JMP/BEQZ/illegal 3.
- Each memory wait cycle adds one cycle to FETCH or MEM, and all outputs hold steady during the wait.
- `en_de`, `alu_en` and `reg_we` are never high in the same cycle; `mem_req` is only high in FETCH/MEM.

Test Plan:
1. Reset/idle: `rst`=1 for 2 cycles, then `start`=0 for 5 cycles -> `state_o`=0, `pc`=0, all strobes 0, `mem_req`=0.
2. ALU: `mem_ready`=1, mem[0]=32'h00010200 (opcode 0, func 0), pulse `start` -> states 1,2,3,5 on consecutive cycles. `en_de` high in cycle 2, `alu_en` in cycle 3, `reg_we` in cycle 4, `pc`=1.
3. LOAD with wait: mem[0] has opcode 6'h01 and `addr_cpu`=24'h000010; `mem_ready` low for 2 cycles in MEM -> `mem_addr`=24'h000010 and `mem_we`=0 held for 3 cycles, then WB `reg_we` pulse. STORE variant: `mem_we`=1 and no WB.
4. Branching: JMP to 24'h000100 -> next FETCH `mem_addr`=24'h000100. BEQZ with `zero_flag`=0 -> `pc` unchanged (1). BEQZ with `zero_flag`=1 -> `pc`=`addr_q`.
5. Edge cases:
   - Opcode 6'h2A -> `illegal` pulses once, then next FETCH.
   - Opcode 6'h3F -> `halted`=1, `state_o`=6, `start` ignored for 10 cycles.
   - `pc`=24'hFFFFFF fetch -> `pc`=0.
6. Mid-op reset: assert `rst` during MEM with `mem_req`=1 -> next cycle `state_o`=0, `mem_req`=0, `pc`=PC_RESET.
